// File: rtl/stopwatch_pkg.sv
// -----------------------------------------------------------------------------
// stopwatch_pkg
//   Shared types and clock-dependent constants for the stopwatch slice.
//   - key_state_t : per-key debounce FSM state
//   - DEFAULT_*   : debounce / hold defaults for a 50 MHz system clock
//   - width helpers for the per-key counters
// -----------------------------------------------------------------------------
package stopwatch_pkg;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } key_state_t;

    // 20 ms debounce and 2 s long-hold at 50 MHz.
    localparam int unsigned DEFAULT_NUM_KEYS        = 2;
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 1_000_000;
    localparam int unsigned DEFAULT_HOLD_CYCLES     = 100_000_000;

    // Debounce counter only ever holds 0 .. DEBOUNCE_CYCLES-1.
    function automatic int unsigned debounce_width(input int unsigned cycles);
        return (cycles < 2) ? 1 : $clog2(cycles);
    endfunction

    // Hold counter saturates at HOLD_CYCLES, so it must represent that value.
    function automatic int unsigned hold_width(input int unsigned cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/key_conditioner_if.sv
// -----------------------------------------------------------------------------
// key_conditioner_if
//   Bundle of the per-key signals between the raw buttons and the stopwatch.
//   key_n         : raw active-low buttons (asynchronous)
//   key_level_n   : debounced level, active-low
//   press_pulse   : one-cycle strobe on accepted press
//   release_pulse : one-cycle strobe on accepted release
//   hold_pulse    : one-cycle strobe after the long-hold time
//   master : button side / consumer (drives key_n, sees conditioned outputs)
//   slave  : key_conditioner side
// -----------------------------------------------------------------------------
interface key_conditioner_if
    import stopwatch_pkg::*;
#(
    parameter int unsigned NUM_KEYS = DEFAULT_NUM_KEYS
);

    logic [NUM_KEYS-1:0] key_n;
    logic [NUM_KEYS-1:0] key_level_n;
    logic [NUM_KEYS-1:0] press_pulse;
    logic [NUM_KEYS-1:0] release_pulse;
    logic [NUM_KEYS-1:0] hold_pulse;

    modport master (
        output key_n,
        input  key_level_n,
        input  press_pulse,
        input  release_pulse,
        input  hold_pulse
    );

    modport slave (
        input  key_n,
        output key_level_n,
        output press_pulse,
        output release_pulse,
        output hold_pulse
    );

endinterface

// File: rtl/key_channel.sv
// -----------------------------------------------------------------------------
// key_channel
//   One push-button channel: 2-flop synchroniser, debounce FSM, debounce
//   counter and long-hold counter. All outputs are registered.
//   clk           : system clock
//   rstn          : asynchronous active-low reset
//   key_n         : raw active-low button, asynchronous to clk
//   key_level_n   : debounced level (0 while PRESSED or RELEASE_WAIT)
//   press_pulse   : 1 cycle on PRESS_WAIT -> PRESSED
//   release_pulse : 1 cycle on RELEASE_WAIT -> RELEASED
//   hold_pulse    : 1 cycle when the hold counter first reaches HOLD_CYCLES
// -----------------------------------------------------------------------------
module key_channel
    import stopwatch_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned HOLD_CYCLES     = DEFAULT_HOLD_CYCLES
) (
    input  logic clk,
    input  logic rstn,
    input  logic key_n,
    output logic key_level_n,
    output logic press_pulse,
    output logic release_pulse,
    output logic hold_pulse
);

    localparam int unsigned DB_W   = debounce_width(DEBOUNCE_CYCLES);
    localparam int unsigned HOLD_W = hold_width(HOLD_CYCLES);

    localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    logic              sync_1;
    logic              sync_2;
    key_state_t        state;
    logic [DB_W-1:0]   db_cnt;
    logic [HOLD_W-1:0] hold_cnt;

    logic              hold_sat;
    logic              hold_hit;

    // Synchroniser idles at 1 so a key held through reset is seen as a fresh
    // falling edge once reset lifts.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
        end else begin
            sync_1 <= key_n;
            sync_2 <= sync_1;
        end
    end

    always_comb begin
        hold_sat = (hold_cnt == HOLD_MAX);
        hold_hit = (hold_cnt == HOLD_LAST);
    end

    // db_cnt counts accepted stable samples; the sample that would make the
    // count equal DEBOUNCE_CYCLES triggers the transition instead of being
    // stored, so the counter never needs to hold DEBOUNCE_CYCLES itself.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= RELEASED;
            db_cnt        <= '0;
            hold_cnt      <= '0;
            key_level_n   <= 1'b1;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            hold_pulse    <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            hold_pulse    <= 1'b0;

            case (state)
                RELEASED: begin
                    hold_cnt <= '0;
                    if (!sync_2) begin
                        state  <= PRESS_WAIT;
                        db_cnt <= DB_ONE;
                    end
                end

                PRESS_WAIT: begin
                    hold_cnt <= '0;
                    if (sync_2) begin
                        state  <= RELEASED;
                        db_cnt <= '0;
                    end else if (db_cnt == DB_LAST) begin
                        state       <= PRESSED;
                        db_cnt      <= '0;
                        key_level_n <= 1'b0;
                        press_pulse <= 1'b1;
                    end else begin
                        db_cnt <= db_cnt + DB_ONE;
                    end
                end

                PRESSED: begin
                    if (!hold_sat) begin
                        hold_cnt <= hold_cnt + HOLD_ONE;
                        if (hold_hit) begin
                            hold_pulse <= 1'b1;
                        end
                    end
                    if (sync_2) begin
                        state  <= RELEASE_WAIT;
                        db_cnt <= DB_ONE;
                    end
                end

                RELEASE_WAIT: begin
                    if (sync_2 && (db_cnt == DB_LAST)) begin
                        // Accepted release wins over a coincident hold tick.
                        state         <= RELEASED;
                        db_cnt        <= '0;
                        hold_cnt      <= '0;
                        key_level_n   <= 1'b1;
                        release_pulse <= 1'b1;
                    end else begin
                        // Bounce back to PRESSED keeps the accumulated hold time.
                        if (!hold_sat) begin
                            hold_cnt <= hold_cnt + HOLD_ONE;
                            if (hold_hit) begin
                                hold_pulse <= 1'b1;
                            end
                        end
                        if (!sync_2) begin
                            state  <= PRESSED;
                            db_cnt <= '0;
                        end else begin
                            db_cnt <= db_cnt + DB_ONE;
                        end
                    end
                end

                default: begin
                    state    <= RELEASED;
                    db_cnt   <= '0;
                    hold_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/key_conditioner.sv
// -----------------------------------------------------------------------------
// key_conditioner
//   Push-button front end for the stopwatch. Each of NUM_KEYS raw active-low
//   buttons is synchronised and debounced independently by a key_channel.
//   Bit 0 = start/stop, bit 1 = lap/reset.
//   clk  : system clock
//   rstn : asynchronous active-low reset
//   kif  : key_conditioner_if slave (key_n in; key_level_n, press_pulse,
//          release_pulse, hold_pulse out, all NUM_KEYS wide)
// -----------------------------------------------------------------------------
module key_conditioner
    import stopwatch_pkg::*;
#(
    parameter int unsigned NUM_KEYS        = DEFAULT_NUM_KEYS,
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned HOLD_CYCLES     = DEFAULT_HOLD_CYCLES
) (
    input  logic               clk,
    input  logic               rstn,
    key_conditioner_if.slave   kif
);

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .HOLD_CYCLES     (HOLD_CYCLES)
        ) u_key_channel (
            .clk           (clk),
            .rstn          (rstn),
            .key_n         (kif.key_n[i]),
            .key_level_n   (kif.key_level_n[i]),
            .press_pulse   (kif.press_pulse[i]),
            .release_pulse (kif.release_pulse[i]),
            .hold_pulse    (kif.hold_pulse[i])
        );
    end

endmodule

// File: tb/tb_key_conditioner.sv
// -----------------------------------------------------------------------------
// tb_key_conditioner
//   Scoreboard bench for key_conditioner with DEBOUNCE_CYCLES=4,
//   HOLD_CYCLES=10, NUM_KEYS=2. Stimulus pushes the expected pulse events
//   (edge number, pulse vectors, level after the edge); a monitor pops one
//   entry whenever any pulse is high and compares.
// -----------------------------------------------------------------------------
module tb_key_conditioner;

    localparam int unsigned NK = 2;
    localparam int unsigned DB = 4;
    localparam int unsigned HC = 10;

    typedef struct {
        int         cyc;
        logic [1:0] press;
        logic [1:0] rel;
        logic [1:0] hold;
        logic [1:0] level;
        string      name;
    } ev_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   cyc  = 0;
    int   errors = 0;
    int   checks = 0;
    ev_t  exp_q[$];

    always #5 clk = ~clk;

    // Number of rising edges so far; stable when read at the falling edge.
    always @(posedge clk) cyc <= cyc + 1;

    key_conditioner_if #(.NUM_KEYS(NK)) kif ();

    key_conditioner #(
        .NUM_KEYS        (NK),
        .DEBOUNCE_CYCLES (DB),
        .HOLD_CYCLES     (HC)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .kif  (kif)
    );

    task automatic check2(input string name, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (edge %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_ev(input int c, input logic [1:0] p, input logic [1:0] r,
                           input logic [1:0] h, input logic [1:0] l, input string name);
        ev_t e;
        e.cyc = c; e.press = p; e.rel = r; e.hold = h; e.level = l; e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_idle(input string name);
        check2({name, "_level"},   kif.key_level_n,   2'b11);
        check2({name, "_press"},   kif.press_pulse,   2'b00);
        check2({name, "_release"}, kif.release_pulse, 2'b00);
        check2({name, "_hold"},    kif.hold_pulse,    2'b00);
    endtask

    // Monitor: every pulse cycle must match the next expected event.
    always @(negedge clk) begin
        ev_t e;
        if ((|kif.press_pulse) || (|kif.release_pulse) || (|kif.hold_pulse)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: got press=%b release=%b hold=%b at edge %0d, required none",
                         kif.press_pulse, kif.release_pulse, kif.hold_pulse, cyc);
            end else begin
                e = exp_q.pop_front();
                check_int({e.name, "_edge"}, cyc, e.cyc);
                check2({e.name, "_press"},   kif.press_pulse,   e.press);
                check2({e.name, "_release"}, kif.release_pulse, e.rel);
                check2({e.name, "_hold"},    kif.hold_pulse,    e.hold);
                check2({e.name, "_level"},   kif.key_level_n,   e.level);
            end
        end
    end

    initial begin
        int e;
        int e2;
        kif.key_n = 2'b11;
        rstn      = 1'b0;
        wait_neg(3);
        check_idle("reset");
        rstn = 1'b1;
        wait_neg(3);

        // Clean press, long hold, no repeat, release on key 0.
        e = cyc + 1;
        kif.key_n[0] = 1'b0;
        push_ev(e + 5,  2'b01, 2'b00, 2'b00, 2'b10, "press0");
        push_ev(e + 15, 2'b00, 2'b00, 2'b01, 2'b10, "hold0");
        wait_neg(4);
        check2("press0_not_early", kif.key_level_n, 2'b11);
        wait_neg(2);
        check2("press0_level_ch1_idle", kif.key_level_n, 2'b10);
        wait_neg(60);
        e = cyc + 1;
        kif.key_n[0] = 1'b1;
        push_ev(e + 5, 2'b00, 2'b01, 2'b00, 2'b11, "release0");
        wait_neg(12);

        // Bounce: 3 low, 1 high, 3 low, then high -> nothing accepted.
        kif.key_n[0] = 1'b0;
        wait_neg(3);
        kif.key_n[0] = 1'b1;
        wait_neg(1);
        kif.key_n[0] = 1'b0;
        wait_neg(3);
        kif.key_n[0] = 1'b1;
        wait_neg(2);
        check2("bounce_level_mid", kif.key_level_n, 2'b11);
        wait_neg(10);
        check2("bounce_level_end", kif.key_level_n, 2'b11);

        // Both keys on the same edge.
        e = cyc + 1;
        kif.key_n = 2'b00;
        push_ev(e + 5,  2'b11, 2'b00, 2'b00, 2'b00, "press_both");
        push_ev(e + 15, 2'b00, 2'b00, 2'b11, 2'b00, "hold_both");
        wait_neg(20);
        e = cyc + 1;
        kif.key_n = 2'b11;
        push_ev(e + 5, 2'b00, 2'b11, 2'b00, 2'b11, "release_both");
        wait_neg(12);

        // Reset two cycles into PRESS_WAIT on key 1, key stays held.
        kif.key_n[1] = 1'b0;
        wait_neg(4);
        rstn = 1'b0;
        #1;
        check_idle("midreset_assert");
        wait_neg(3);
        check_idle("midreset_held");
        rstn = 1'b1;
        e = cyc + 1;
        push_ev(e + 5,  2'b10, 2'b00, 2'b00, 2'b01, "press1_after_reset");
        push_ev(e + 15, 2'b00, 2'b00, 2'b10, 2'b01, "hold1");
        wait_neg(20);
        e = cyc + 1;
        kif.key_n[1] = 1'b1;
        push_ev(e + 5, 2'b00, 2'b10, 2'b00, 2'b11, "release1");
        wait_neg(12);

        // Short hold: release 5 cycles after pressing; hold never fires.
        e = cyc + 1;
        kif.key_n[0] = 1'b0;
        push_ev(e + 5, 2'b01, 2'b00, 2'b00, 2'b10, "short_press0");
        wait_neg(5);
        e2 = cyc + 1;
        kif.key_n[0] = 1'b1;
        push_ev(e2 + 5, 2'b00, 2'b01, 2'b00, 2'b11, "short_release0");
        wait_neg(30);
        check2("final_level", kif.key_level_n, 2'b11);

        check_int("events_outstanding", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
